// File: rtl/instruction_fetch_unit_pkg.sv
// instruction_fetch_unit_pkg: shared core opcodes, widths and fetch state enum
package instruction_fetch_unit_pkg;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_INS_W = 20;
  localparam logic [4:0] OP_HLT = 5'b10001;
  localparam logic [4:0] OP_LD = 5'b10100;
  localparam logic [2:0] JMP_CLASS = 3'b111;
  typedef enum logic {RUN, HALT} state_e;
endpackage

// File: rtl/instruction_fetch_unit_pc_register.sv
// instruction_fetch_unit_pc_register: program counter with load > hold > increment priority
module instruction_fetch_unit_pc_register #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              hold_i,
  input  logic [ADDR_W-1:0] load_val_i,
  output logic [ADDR_W-1:0] pc_o
);
  logic [ADDR_W-1:0] pc_q, pc_d;
  always_comb pc_d = load_i ? load_val_i : hold_i ? pc_q : pc_q + 1'b1;
  always_ff @(posedge clk or posedge rst_i)
    if (rst_i) pc_q <= '0;
    else pc_q <= pc_d;
  assign pc_o = pc_q;
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the PC, replays stalled instructions to decode and halts on HLT
module instruction_fetch_unit import instruction_fetch_unit_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int INS_W = DEF_INS_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              stall_pm,
  input  logic [INS_W-1:0]  ins_pm,
  input  logic [ADDR_W-1:0] jmp_loc,
  input  logic              pc_mux_sel,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [INS_W-1:0]  ins,
  output logic [ADDR_W-1:0] current_address,
  output logic              halted
);
  state_e state_q, state_d;
  logic [INS_W-1:0] ins_prev_q;
  logic [ADDR_W-1:0] addr_prev_q, pc;
  logic halt, is_hlt;
  assign halt = (state_q == HALT);
  instruction_fetch_unit_pc_register #(.ADDR_W(ADDR_W)) u_pc (
    .clk(clk),
    .rst_i(reset),
    .load_i(!halt && pc_mux_sel),
    .hold_i(halt || stall),
    .load_val_i(jmp_loc),
    .pc_o(pc)
  );
  // HALT feeds NOPs so decode never sees the HLT twice; the address stays pinned via addr_prev
  always_comb begin
    ins = (reset || halt) ? '0 : stall_pm ? ins_prev_q : ins_pm;
    current_address = (halt || stall_pm) ? addr_prev_q : pc;
    is_hlt = (ins[INS_W-1 -: 5] == OP_HLT);
    state_d = (!halt && is_hlt && !stall_pm && !pc_mux_sel) ? HALT : state_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= RUN;
      ins_prev_q <= '0;
      addr_prev_q <= '0;
    end else begin
      state_q <= state_d;
      ins_prev_q <= ins;
      addr_prev_q <= current_address;
    end
  assign pm_addr = pc;
  assign halted = halt;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: table-driven directed checks plus reset/halt-squash sequences
module tb_instruction_fetch_unit;
  logic clk = 0;
  logic reset, stall, stall_pm, pc_mux_sel;
  logic [19:0] ins_pm, ins;
  logic [7:0] jmp_loc, pm_addr, current_address;
  logic halted;
  logic [19:0] mem [256];
  int checks = 0, failures = 0;

  typedef struct {
    logic st, sp, js;
    logic [7:0] jl, pa;
    logic [19:0] in;
    logic [7:0] ca;
    logic h;
  } vec_t;
  vec_t v [18];

  instruction_fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .stall_pm(stall_pm), .ins_pm(ins_pm),
    .jmp_loc(jmp_loc), .pc_mux_sel(pc_mux_sel), .pm_addr(pm_addr), .ins(ins),
    .current_address(current_address), .halted(halted)
  );

  assign ins_pm = mem[pm_addr];
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drv(input logic st, input logic sp, input logic js, input logic [7:0] jl);
    stall = st; stall_pm = sp; pc_mux_sel = js; jmp_loc = jl;
  endtask

  function automatic vec_t mk(input logic st, input logic sp, input logic js, input logic [7:0] jl,
                              input logic [7:0] pa, input logic [19:0] in, input logic [7:0] ca, input logic h);
    vec_t r;
    r.st = st; r.sp = sp; r.js = js; r.jl = jl; r.pa = pa; r.in = in; r.ca = ca; r.h = h;
    return r;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {5'b00001, 7'h2A, 8'(i)};
    mem[3] = 20'hE0003;
    mem[5] = 20'hA0005;
    mem[9] = 20'h88009;
    v[0]  = mk(0, 0, 0, 8'h00, 8'h00, mem[8'h00], 8'h00, 0);
    v[1]  = mk(0, 0, 0, 8'h00, 8'h01, mem[8'h01], 8'h01, 0);
    v[2]  = mk(0, 0, 0, 8'h00, 8'h02, mem[8'h02], 8'h02, 0);
    v[3]  = mk(1, 0, 1, 8'h40, 8'h03, mem[8'h03], 8'h03, 0);
    v[4]  = mk(0, 0, 0, 8'h00, 8'h40, mem[8'h40], 8'h40, 0);
    v[5]  = mk(0, 0, 1, 8'h05, 8'h41, mem[8'h41], 8'h41, 0);
    v[6]  = mk(0, 0, 0, 8'h00, 8'h05, mem[8'h05], 8'h05, 0);
    v[7]  = mk(1, 0, 0, 8'h00, 8'h06, mem[8'h06], 8'h06, 0);
    v[8]  = mk(0, 1, 0, 8'h00, 8'h06, mem[8'h06], 8'h06, 0);
    v[9]  = mk(0, 0, 1, 8'hFE, 8'h07, mem[8'h07], 8'h07, 0);
    v[10] = mk(0, 0, 0, 8'h00, 8'hFE, mem[8'hFE], 8'hFE, 0);
    v[11] = mk(0, 0, 0, 8'h00, 8'hFF, mem[8'hFF], 8'hFF, 0);
    v[12] = mk(0, 0, 0, 8'h00, 8'h00, mem[8'h00], 8'h00, 0);
    v[13] = mk(0, 0, 1, 8'h09, 8'h01, mem[8'h01], 8'h01, 0);
    v[14] = mk(0, 0, 0, 8'h00, 8'h09, mem[8'h09], 8'h09, 0);
    v[15] = mk(1, 0, 0, 8'h00, 8'h0A, 20'h0, 8'h09, 1);
    v[16] = mk(1, 0, 1, 8'h20, 8'h0A, 20'h0, 8'h09, 1);
    v[17] = mk(1, 0, 0, 8'h00, 8'h0A, 20'h0, 8'h09, 1);

    reset = 1;
    drv(0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("rst_pm_addr", 32'(pm_addr), 0);
    chk("rst_ins", 32'(ins), 0);
    chk("rst_cur", 32'(current_address), 0);
    chk("rst_halted", 32'(halted), 0);
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 18; i++) begin
      drv(v[i].st, v[i].sp, v[i].js, v[i].jl);
      #1;
      chk($sformatf("v%0d_pm_addr", i), 32'(pm_addr), 32'(v[i].pa));
      chk($sformatf("v%0d_ins", i), 32'(ins), 32'(v[i].in));
      chk($sformatf("v%0d_cur", i), 32'(current_address), 32'(v[i].ca));
      chk($sformatf("v%0d_halted", i), 32'(halted), 32'(v[i].h));
      @(negedge clk);
    end

    // leave HALT only through reset
    drv(0, 0, 0, 0);
    reset = 1;
    #1;
    chk("halt_rst_halted", 32'(halted), 0);
    chk("halt_rst_pm_addr", 32'(pm_addr), 0);
    chk("halt_rst_ins", 32'(ins), 0);
    @(negedge clk);
    reset = 0;

    // HLT arriving with a redirect is squashed
    drv(0, 0, 1, 8'h09);
    #1;
    chk("sq_pm0", 32'(pm_addr), 0);
    @(negedge clk);
    drv(0, 0, 1, 8'h20);
    #1;
    chk("sq_pm9", 32'(pm_addr), 32'h09);
    chk("sq_ins_hlt", 32'(ins), 32'(mem[9]));
    @(negedge clk);
    drv(0, 0, 0, 0);
    #1;
    chk("sq_pm20", 32'(pm_addr), 32'h20);
    chk("sq_ins20", 32'(ins), 32'(mem[8'h20]));
    chk("sq_halted", 32'(halted), 0);
    @(negedge clk);

    // asynchronous reset mid-run at 0x33
    drv(0, 0, 1, 8'h33);
    @(negedge clk);
    drv(0, 0, 0, 0);
    #1;
    chk("mr_pm33", 32'(pm_addr), 32'h33);
    #2;
    reset = 1;
    #1;
    chk("mr_pm_addr", 32'(pm_addr), 0);
    chk("mr_ins", 32'(ins), 0);
    chk("mr_cur", 32'(current_address), 0);
    chk("mr_halted", 32'(halted), 0);
    @(negedge clk);
    reset = 0;
    #1;
    chk("mr_rel_pm0", 32'(pm_addr), 0);
    chk("mr_rel_ins0", 32'(ins), 32'(mem[0]));
    @(negedge clk);
    #1;
    chk("mr_rel_pm1", 32'(pm_addr), 1);
    chk("mr_rel_ins1", 32'(ins), 32'(mem[1]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
